// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of NUM_REQ one-entry result buffers onto a registered CDB; optional stall statistics under CDB_ARB_STATS_EN
module cdb_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int STALL_CNT_W = 16,
  parameter int TAG_W       = 6
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]     req_tag_i,
  input  logic [NUM_REQ-1:0][31:0]          req_val_i,
  input  logic [NUM_REQ-1:0]                req_spec_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic                              flush_i,
  input  logic                              commit_i,
`ifdef CDB_ARB_STATS_EN
  output logic [NUM_REQ-1:0][STALL_CNT_W-1:0] stall_cnt_o,
`endif
  output logic [TAG_W+31:0]                 cdb_o
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TAG_W-1:0] NO_VAL = '0;
  logic [NUM_REQ-1:0]             r_buf_v;
  logic [NUM_REQ-1:0][TAG_W-1:0]  r_buf_tag;
  logic [NUM_REQ-1:0][31:0]       r_buf_val;
  logic [NUM_REQ-1:0]             r_buf_spec;
  logic [PW-1:0]                  r_rr_ptr;
  logic [TAG_W-1:0]               r_cdb_tag;
  logic [31:0]                    r_cdb_val;
  logic [PW-1:0]                  w_cand [NUM_REQ];
  logic [NUM_REQ-1:0]             w_gnt;
  logic [PW-1:0]                  w_gnt_idx;
  logic                           w_gnt_any;
  logic                           w_commit;
  logic                           w_bcast;
  logic [NUM_REQ-1:0]             w_load;
  // search order: rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) w_cand[i] = PW'((int'(r_rr_ptr) + i) % NUM_REQ);
  end
  // one-hot grant to the first valid buffer in search order; last write wins so scan backwards
  always_comb begin
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r_buf_v[w_cand[i]]) begin
        w_gnt_idx = w_cand[i];
        w_gnt_any = 1'b1;
      end
    end
    w_gnt = w_gnt_any ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  end
  // flush overrides commit; a squashed grant still consumes its slot but is not broadcast
  always_comb begin
    w_commit    = commit_i & ~flush_i;
    w_bcast     = w_gnt_any & ~(flush_i & r_buf_spec[w_gnt_idx]);
    req_ready_o = ~r_buf_v | w_gnt;
    w_load      = '0;
    for (int k = 0; k < NUM_REQ; k++)
      w_load[k] = req_valid_i[k] & req_ready_o[k] & (req_tag_i[k] != NO_VAL) & ~(flush_i & req_spec_i[k]);
  end
  // holding buffers: load takes priority over drain, flush squash and commit
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_buf_v    <= '0;
      r_buf_tag  <= '0;
      r_buf_val  <= '0;
      r_buf_spec <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w_load[k]) begin
          r_buf_v[k]    <= 1'b1;
          r_buf_tag[k]  <= req_tag_i[k];
          r_buf_val[k]  <= req_val_i[k];
          r_buf_spec[k] <= req_spec_i[k] & ~w_commit;
        end else begin
          if (w_gnt[k] | (flush_i & r_buf_spec[k])) r_buf_v[k] <= 1'b0;
          if (w_commit) r_buf_spec[k] <= 1'b0;
        end
      end
    end
  end
  // round-robin pointer and registered bus; idle keeps the last value, only the tag goes NO_VAL
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_rr_ptr  <= '0;
      r_cdb_tag <= NO_VAL;
      r_cdb_val <= '0;
    end else begin
      if (w_gnt_any) r_rr_ptr <= PW'((int'(w_gnt_idx) + 1) % NUM_REQ);
      r_cdb_tag <= w_bcast ? r_buf_tag[w_gnt_idx] : NO_VAL;
      if (w_bcast) r_cdb_val <= r_buf_val[w_gnt_idx];
    end
  end
  assign cdb_o = {r_cdb_tag, r_cdb_val};
`ifdef CDB_ARB_STATS_EN
  logic [NUM_REQ-1:0][STALL_CNT_W-1:0] r_stall;
  // saturating count of cycles a requester is valid but refused
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_stall <= '0;
    else
      for (int k = 0; k < NUM_REQ; k++)
        if (req_valid_i[k] & ~req_ready_o[k] & ~&r_stall[k]) r_stall[k] <= r_stall[k] + STALL_CNT_W'(1);
  end
  assign stall_cnt_o = r_stall;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table vectors, directed corner sequences and a random run against a queue-free behavioural model
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 6;
  localparam int SW = 8;
  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  logic [N-1:0] req_valid_i, req_spec_i, req_ready_o;
  logic [N-1:0][TW-1:0] req_tag_i;
  logic [N-1:0][31:0] req_val_i;
  logic flush_i, commit_i;
  logic [TW+31:0] cdb_o;
`ifdef CDB_ARB_STATS_EN
  logic [N-1:0][SW-1:0] stall_cnt_o;
`endif
  always #5 clk_i = ~clk_i;
  cdb_arbiter #(.NUM_REQ(N), .STALL_CNT_W(SW), .TAG_W(TW)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .req_valid_i(req_valid_i), .req_tag_i(req_tag_i),
    .req_val_i(req_val_i), .req_spec_i(req_spec_i), .req_ready_o(req_ready_o),
    .flush_i(flush_i), .commit_i(commit_i),
`ifdef CDB_ARB_STATS_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .cdb_o(cdb_o));
  always @(posedge clk_i)
    if (reset_ni && flush_i && commit_i) $error("protocol error: flush_i and commit_i asserted together");
  int checks = 0, failures = 0;
  bit mv[N], ms[N];
  int mt[N];
  logic [31:0] mval[N];
  int mptr, mctag, mstall[N];
  logic [31:0] mcval;
  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] spec;
    logic         flush;
    logic [N-1:0] exp_ready;
    logic [TW-1:0] exp_tag;
  } vec_t;
  vec_t tbl[14];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic int m_grant();
    for (int i = 0; i < N; i++) if (mv[(mptr + i) % N]) return (mptr + i) % N;
    return -1;
  endfunction
  function automatic logic [N-1:0] m_rdy();
    logic [N-1:0] r;
    int g = m_grant();
    for (int k = 0; k < N; k++) r[k] = !mv[k] || g == k;
    return r;
  endfunction
  task automatic m_reset();
    for (int k = 0; k < N; k++) begin mv[k] = 0; ms[k] = 0; mt[k] = 0; mval[k] = '0; mstall[k] = 0; end
    mptr = 0; mctag = 0; mcval = '0;
  endtask
  task automatic m_clock();
    int g = m_grant();
    logic [N-1:0] r = m_rdy();
    if (g >= 0 && !(flush_i && ms[g])) begin mctag = mt[g]; mcval = mval[g]; end
    else mctag = 0;
    if (g >= 0) begin mptr = (g + 1) % N; mv[g] = 0; end
    if (flush_i) begin
      for (int k = 0; k < N; k++) if (ms[k]) mv[k] = 0;
    end else if (commit_i) begin
      for (int k = 0; k < N; k++) ms[k] = 0;
    end
    for (int k = 0; k < N; k++) begin
      if (req_valid_i[k] && !r[k] && mstall[k] < (1 << SW) - 1) mstall[k]++;
      if (req_valid_i[k] && r[k] && req_tag_i[k] != 0 && !(flush_i && req_spec_i[k])) begin
        mv[k] = 1; mt[k] = int'(req_tag_i[k]); mval[k] = req_val_i[k]; ms[k] = req_spec_i[k] && !commit_i;
      end
    end
  endtask
  task automatic idle_inputs();
    req_valid_i = '0; req_spec_i = '0; req_tag_i = '0; req_val_i = '0; flush_i = 0; commit_i = 0;
  endtask
  task automatic tick();
    #1;
    chk("ready", req_ready_o, m_rdy());
    m_clock();
    @(posedge clk_i);
    #1;
    chk("cdb_tag", cdb_o[TW+31:32], mctag[TW-1:0]);
    chk("cdb_val", cdb_o[31:0], mcval);
`ifdef CDB_ARB_STATS_EN
    for (int k = 0; k < N; k++) chk("stall_cnt", stall_cnt_o[k], mstall[k][SW-1:0]);
`endif
    @(negedge clk_i);
  endtask
  task automatic do_reset();
    reset_ni = 0;
    idle_inputs();
    m_reset();
    @(negedge clk_i);
    chk("reset_cdb", cdb_o, '0);
    chk("reset_ready", req_ready_o, {N{1'b1}});
    reset_ni = 1;
  endtask
  task automatic tagged_inputs(input int base);
    for (int k = 0; k < N; k++) begin req_tag_i[k] = TW'(base + k); req_val_i[k] = 32'h100 + k; end
  endtask
  int seen_a, seen_b;
  int per_tag[N];
  initial begin
    idle_inputs();
    m_reset();
    tbl[0]  = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 6'd0};
    tbl[1]  = '{4'b1111, 4'b0000, 1'b0, 4'b0001, 6'd10};
    tbl[2]  = '{4'b1111, 4'b0000, 1'b0, 4'b0010, 6'd11};
    tbl[3]  = '{4'b1111, 4'b0000, 1'b0, 4'b0100, 6'd12};
    tbl[4]  = '{4'b1111, 4'b0000, 1'b0, 4'b1000, 6'd13};
    tbl[5]  = '{4'b1111, 4'b0000, 1'b0, 4'b0001, 6'd10};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 4'b0010, 6'd11};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 4'b0110, 6'd12};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 4'b1110, 6'd13};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 4'b1111, 6'd10};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 4'b1111, 6'd0};
    tbl[11] = '{4'b0110, 4'b0010, 1'b0, 4'b1111, 6'd0};
    tbl[12] = '{4'b0000, 4'b0000, 1'b1, 4'b1011, 6'd0};
    tbl[13] = '{4'b0000, 4'b0000, 1'b0, 4'b1111, 6'd12};
    repeat (2) @(negedge clk_i);
    do_reset();
    // table: contention rotation, drain and flush of a speculative grant
    for (int i = 0; i < 14; i++) begin
      tagged_inputs(10);
      req_valid_i = tbl[i].valid; req_spec_i = tbl[i].spec; flush_i = tbl[i].flush;
      #1;
      chk($sformatf("tbl%0d_ready", i), req_ready_o, tbl[i].exp_ready);
      m_clock();
      @(posedge clk_i);
      #1;
      chk($sformatf("tbl%0d_tag", i), cdb_o[TW+31:32], tbl[i].exp_tag);
      @(negedge clk_i);
    end
    idle_inputs();
    // async reset mid-traffic
    do_reset();
    tagged_inputs(20);
    req_valid_i = '1;
    repeat (3) tick();
    #2 reset_ni = 0;
    #1;
    chk("async_rst_tag", cdb_o[TW+31:32], '0);
    chk("async_rst_ready", req_ready_o, {N{1'b1}});
    idle_inputs();
    m_reset();
    @(negedge clk_i);
    reset_ni = 1;
    // single result latency
    do_reset();
    req_valid_i = 4'b0001; req_tag_i[0] = 6'd3; req_val_i[0] = 32'hDEAD_BEEF;
    tick();
    chk("single_t0", cdb_o[TW+31:32], '0);
    idle_inputs();
    tick();
    chk("single_tag", cdb_o[TW+31:32], 6'd3);
    chk("single_val", cdb_o[31:0], 32'hDEAD_BEEF);
    tick();
    chk("single_idle", cdb_o[TW+31:32], '0);
    chk("single_hold", cdb_o[31:0], 32'hDEAD_BEEF);
    // fairness: one broadcast per requester per 4 cycles
    do_reset();
    tagged_inputs(10);
    req_valid_i = '1;
    tick();
    for (int k = 0; k < N; k++) per_tag[k] = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      for (int k = 0; k < N; k++) if (cdb_o[TW+31:32] == TW'(10 + k)) per_tag[k]++;
    end
    for (int k = 0; k < N; k++) chk($sformatf("fair%0d", k), per_tag[k], 4);
    // flush squashes spec tag 5, keeps non-spec tag 6
    do_reset();
    req_valid_i = 4'b0110; req_tag_i[1] = 6'd5; req_tag_i[2] = 6'd6; req_spec_i = 4'b0010;
    tick();
    idle_inputs();
    flush_i = 1;
    seen_a = 0; seen_b = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      flush_i = 0;
      if (cdb_o[TW+31:32] == 6'd5) seen_a++;
      if (cdb_o[TW+31:32] == 6'd6 && c < 2) seen_b++;
    end
    chk("flush_spec_seen", seen_a, 0);
    chk("flush_nonspec_seen", seen_b, 1);
    // commit then flush: tag 7 survives
    do_reset();
    tagged_inputs(20);
    req_tag_i[3] = 6'd7; req_spec_i = 4'b1000; req_valid_i = '1;
    tick();
    idle_inputs();
    commit_i = 1;
    seen_a = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      commit_i = 0;
      flush_i = (c == 0);
      if (cdb_o[TW+31:32] == 6'd7) seen_a++;
    end
    chk("commit_survive", seen_a, 1);
`ifdef CDB_ARB_STATS_EN
    do_reset();
    tagged_inputs(10);
    req_valid_i = '1;
    repeat (14) tick();
    chk("stall10", stall_cnt_o[1], SW'(10));
    repeat (400) tick();
    chk("stall_sat", stall_cnt_o[1], {SW{1'b1}});
`endif
    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        req_tag_i[k] = TW'($urandom_range(0, 7));
        req_val_i[k] = $urandom;
      end
      req_valid_i = N'($urandom);
      req_spec_i  = N'($urandom);
      flush_i  = ($urandom_range(0, 15) == 0);
      commit_i = !flush_i && ($urandom_range(0, 9) == 0);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
